// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared types and widths.
// Entry record plus default sizing used by the ROB and its users.
package reorder_buffer_pkg;

  localparam int INST_ADDR_WIDTH        = 32;
  localparam int PHYSICAL_REG_NUM_WIDTH = 6;
  localparam int REG_VAL_WIDTH          = 32;
  localparam int ROB_DEPTH              = 16;
  localparam int ROB_TAG_WIDTH          = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic                              valid;
    logic                              done;
    logic [INST_ADDR_WIDTH-1:0]        pc;
    logic                              has_dst;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] dst;
    logic [REG_VAL_WIDTH-1:0]          value;
  } rob_entry_t;

endpackage

// File: rtl/rob_circ_ptr.sv
// Wrapping circular-buffer pointer with a wrap bit.
// Index and wrap bit share one counter so wrap toggles on rollover.
module rob_circ_ptr #(
  parameter  int DEPTH = 16,
  localparam int W     = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_idx,
  output logic         o_wrap
);

  logic [W:0] r_ptr;

  // Advance on request, return to zero on clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + (W+1)'(1);
    end
  end

  assign o_idx  = r_ptr[W-1:0];
  assign o_wrap = r_ptr[W];

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer.
// Allocates at tail, completes from CDB, retires one done head per cycle.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter  int ROB_DEPTH = 16,
  localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_valid,
  input  logic [INST_ADDR_WIDTH-1:0]        alloc_pc,
  input  logic                              alloc_has_dst,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_dst_phy_reg,
  output logic                              alloc_ready,
  output logic [TAG_W-1:0]                  alloc_rob_tag,
  input  logic                              cdb_valid,
  input  logic [TAG_W-1:0]                  cdb_rob_tag,
  input  logic [REG_VAL_WIDTH-1:0]          cdb_value,
  input  logic                              flush,
  output logic                              commit_valid,
  output logic                              commit_with_write,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
  output logic                              commit_wr_en,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] wr_commit_reg,
  output logic [REG_VAL_WIDTH-1:0]          commit_wr_val,
  output logic [INST_ADDR_WIDTH-1:0]        commit_pc,
  output logic [TAG_W:0]                    rob_count,
  output logic                              rob_empty
);

  rob_entry_t r_rob [ROB_DEPTH];

  logic [TAG_W-1:0] w_head_idx;
  logic [TAG_W-1:0] w_tail_idx;
  logic             w_head_wrap;
  logic             w_tail_wrap;
  logic [TAG_W:0]   w_count;
  logic             w_alloc;
  logic             w_commit;
  rob_entry_t       w_head;

  logic                              r_cv;
  logic                              r_cw;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] r_cdst;
  logic [REG_VAL_WIDTH-1:0]          r_cval;
  logic [INST_ADDR_WIDTH-1:0]        r_cpc;

  rob_circ_ptr #(.DEPTH(ROB_DEPTH)) u_head (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (flush),
    .i_inc  (w_commit),
    .o_idx  (w_head_idx),
    .o_wrap (w_head_wrap)
  );

  rob_circ_ptr #(.DEPTH(ROB_DEPTH)) u_tail (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (flush),
    .i_inc  (w_alloc),
    .o_idx  (w_tail_idx),
    .o_wrap (w_tail_wrap)
  );

  // Occupancy is the wrap-extended distance from head to tail.
  assign w_count = {w_tail_wrap, w_tail_idx} - {w_head_wrap, w_head_idx};
  assign w_head  = r_rob[w_head_idx];
  assign w_alloc = alloc_valid & alloc_ready & ~flush;
  assign w_commit = w_head.valid & w_head.done & ~flush;

  // Full exactly when the count reaches 2**TAG_W.
  assign alloc_ready   = ~w_count[TAG_W];
  assign alloc_rob_tag = w_tail_idx;
  assign rob_count     = w_count;
  assign rob_empty     = (w_count == '0);

  // Entry storage: allocate at tail, complete from CDB, retire at head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rob[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rob[i].valid <= 1'b0;
        r_rob[i].done  <= 1'b0;
      end
    end else begin
      if (w_alloc) begin
        r_rob[w_tail_idx].valid   <= 1'b1;
        r_rob[w_tail_idx].done    <= 1'b0;
        r_rob[w_tail_idx].pc      <= alloc_pc;
        r_rob[w_tail_idx].has_dst <= alloc_has_dst;
        r_rob[w_tail_idx].dst     <= alloc_dst_phy_reg;
        r_rob[w_tail_idx].value   <= '0;
      end
      if (cdb_valid && r_rob[cdb_rob_tag].valid) begin
        r_rob[cdb_rob_tag].done  <= 1'b1;
        r_rob[cdb_rob_tag].value <= cdb_value;
      end
      if (w_commit) begin
        r_rob[w_head_idx].valid <= 1'b0;
      end
    end
  end

  // Registered commit port: one-cycle pulse carrying the retired entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cv   <= 1'b0;
      r_cw   <= 1'b0;
      r_cdst <= '0;
      r_cval <= '0;
      r_cpc  <= '0;
    end else if (w_commit) begin
      r_cv   <= 1'b1;
      r_cw   <= w_head.has_dst;
      r_cdst <= w_head.dst;
      r_cval <= w_head.value;
      r_cpc  <= w_head.pc;
    end else begin
      r_cv   <= 1'b0;
      r_cw   <= 1'b0;
      r_cdst <= '0;
      r_cval <= '0;
      r_cpc  <= '0;
    end
  end

  assign commit_valid         = r_cv;
  assign commit_with_write    = r_cw;
  assign commit_wr_en         = r_cw;
  assign commited_wr_register = r_cdst;
  assign wr_commit_reg        = r_cdst;
  assign commit_wr_val        = r_cval;
  assign commit_pc            = r_cpc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed scenarios plus random traffic
// checked against a queue-based in-order retirement model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int D = 16;

  logic                              clk;
  logic                              reset;
  logic                              alloc_valid;
  logic [INST_ADDR_WIDTH-1:0]        alloc_pc;
  logic                              alloc_has_dst;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_dst_phy_reg;
  logic                              alloc_ready;
  logic [3:0]                        alloc_rob_tag;
  logic                              cdb_valid;
  logic [3:0]                        cdb_rob_tag;
  logic [REG_VAL_WIDTH-1:0]          cdb_value;
  logic                              flush;
  logic                              commit_valid;
  logic                              commit_with_write;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register;
  logic                              commit_wr_en;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] wr_commit_reg;
  logic [REG_VAL_WIDTH-1:0]          commit_wr_val;
  logic [INST_ADDR_WIDTH-1:0]        commit_pc;
  logic [4:0]                        rob_count;
  logic                              rob_empty;

  reorder_buffer #(.ROB_DEPTH(D)) dut (
    .clk                  (clk),
    .reset                (reset),
    .alloc_valid          (alloc_valid),
    .alloc_pc             (alloc_pc),
    .alloc_has_dst        (alloc_has_dst),
    .alloc_dst_phy_reg    (alloc_dst_phy_reg),
    .alloc_ready          (alloc_ready),
    .alloc_rob_tag        (alloc_rob_tag),
    .cdb_valid            (cdb_valid),
    .cdb_rob_tag          (cdb_rob_tag),
    .cdb_value            (cdb_value),
    .flush                (flush),
    .commit_valid         (commit_valid),
    .commit_with_write    (commit_with_write),
    .commited_wr_register (commited_wr_register),
    .commit_wr_en         (commit_wr_en),
    .wr_commit_reg        (wr_commit_reg),
    .commit_wr_val        (commit_wr_val),
    .commit_pc            (commit_pc),
    .rob_count            (rob_count),
    .rob_empty            (rob_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic        hd;
    logic [5:0]  dst;
    logic        done;
    logic [31:0] val;
  } ment_t;

  ment_t       q[$];
  int          next_tag;
  logic        e_cv;
  logic        e_cw;
  logic [5:0]  e_dst;
  logic [31:0] e_val;
  logic [31:0] e_pc;
  int          n_cmp;
  int          n_err;

  task automatic model_clear();
    q.delete();
    next_tag = 0;
    e_cv = 0; e_cw = 0; e_dst = 0; e_val = 0; e_pc = 0;
  endtask

  task automatic idle();
    alloc_valid = 0;
    cdb_valid   = 0;
    flush       = 0;
  endtask

  // One clock edge; the model retires/completes/allocates like the spec says.
  task automatic tick();
    bit    can_alloc;
    ment_t e;
    can_alloc = (q.size() < D);
    @(posedge clk);
    e_cv = 0; e_cw = 0; e_dst = 0; e_val = 0; e_pc = 0;
    if (flush) begin
      q.delete();
      next_tag = 0;
    end else begin
      if (q.size() > 0 && q[0].done) begin
        e_cv = 1; e_cw = q[0].hd; e_dst = q[0].dst;
        e_val = q[0].val; e_pc = q[0].pc;
        void'(q.pop_front());
      end
      if (cdb_valid) begin
        foreach (q[i]) begin
          if (q[i].tag == int'(cdb_rob_tag)) begin
            q[i].done = 1;
            q[i].val  = cdb_value;
          end
        end
      end
      if (alloc_valid && can_alloc) begin
        e.tag = next_tag; e.pc = alloc_pc; e.hd = alloc_has_dst;
        e.dst = alloc_dst_phy_reg; e.done = 0; e.val = 0;
        q.push_back(e);
        next_tag = (next_tag + 1) % D;
      end
    end
    #1;
  endtask

  task automatic alloc(input logic hd, input logic [5:0] dst);
    alloc_valid = 1;
    alloc_has_dst = hd;
    alloc_dst_phy_reg = dst;
    alloc_pc = $urandom;
    tick();
    alloc_valid = 0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] v);
    cdb_valid = 1;
    cdb_rob_tag = tag;
    cdb_value = v;
    tick();
    cdb_valid = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle();
    alloc_pc = 0; alloc_has_dst = 0; alloc_dst_phy_reg = 0;
    cdb_rob_tag = 0; cdb_value = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (rob_count !== 5'd0 || rob_empty !== 1'b1) begin
      n_err++;
      $display("FAIL reset_count: count=%0d empty=%b need 0/1", rob_count, rob_empty);
    end
    n_cmp++;
    if (alloc_ready !== 1'b1 || alloc_rob_tag !== 4'd0) begin
      n_err++;
      $display("FAIL reset_alloc: ready=%b tag=%0d need 1/0", alloc_ready, alloc_rob_tag);
    end
    n_cmp++;
    if (commit_valid !== 0 || commit_wr_en !== 0 || commit_wr_val !== 0) begin
      n_err++;
      $display("FAIL reset_commit: cv=%b wen=%b val=%h need 0", commit_valid, commit_wr_en, commit_wr_val);
    end
    reset = 1;
  endtask

  task automatic test_in_order();
    int          seen;
    int          cyc[3];
    logic [5:0]  dsts[3];
    logic [31:0] vals[3];
    logic [5:0]  xd[3];
    logic [31:0] xv[3];
    xd = '{6'd5, 6'd6, 6'd7};
    xv = '{32'hA, 32'hB, 32'hC};
    seen = 0;
    for (int i = 0; i < 3; i++) alloc(1, xd[i]);
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        cdb_valid = 1; cdb_rob_tag = 4'(c); cdb_value = xv[c];
      end else begin
        cdb_valid = 0;
      end
      tick();
      cdb_valid = 0;
      n_cmp++;
      if (commit_valid !== e_cv) begin
        n_err++;
        $display("FAIL inorder_cv cyc%0d: got %b need %b", c, commit_valid, e_cv);
      end
      if (commit_valid === 1'b1 && seen < 3) begin
        cyc[seen] = c; dsts[seen] = commited_wr_register; vals[seen] = commit_wr_val;
        seen++;
      end
    end
    n_cmp++;
    if (seen != 3) begin
      n_err++;
      $display("FAIL inorder_pulses: got %0d need 3", seen);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (dsts[i] !== xd[i] || vals[i] !== xv[i] || cyc[i] != i + 1) begin
          n_err++;
          $display("FAIL inorder_entry%0d: dst=%0d val=%h cyc=%0d need %0d/%h/%0d",
                   i, dsts[i], vals[i], cyc[i], xd[i], xv[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_out_of_order();
    logic [3:0] t0, t1;
    t0 = 4'(next_tag);
    n_cmp++;
    if (alloc_rob_tag !== t0) begin
      n_err++;
      $display("FAIL ooo_tag: got %0d need %0d", alloc_rob_tag, t0);
    end
    alloc(1, 6'd20);
    t1 = 4'(next_tag);
    alloc(1, 6'd21);
    cdb(t1, 32'h11);
    for (int c = 0; c < 3; c++) begin
      idle();
      tick();
      n_cmp++;
      if (commit_valid !== 1'b0) begin
        n_err++;
        $display("FAIL ooo_blocked cyc%0d: cv=%b need 0", c, commit_valid);
      end
    end
    cdb(t0, 32'h10);
    tick();
    n_cmp++;
    if (commit_valid !== 1'b1 || commited_wr_register !== 6'd20 || commit_wr_val !== 32'h10) begin
      n_err++;
      $display("FAIL ooo_first: cv=%b dst=%0d val=%h need 1/20/10", commit_valid, commited_wr_register, commit_wr_val);
    end
    tick();
    n_cmp++;
    if (commit_valid !== 1'b1 || commited_wr_register !== 6'd21 || commit_wr_val !== 32'h11) begin
      n_err++;
      $display("FAIL ooo_second: cv=%b dst=%0d val=%h need 1/21/11", commit_valid, commited_wr_register, commit_wr_val);
    end
  endtask

  task automatic test_full_wrap();
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < D; i++) begin
      n_cmp++;
      if (alloc_rob_tag !== 4'(i) || alloc_ready !== 1'b1) begin
        n_err++;
        $display("FAIL fill_tag%0d: tag=%0d ready=%b need %0d/1", i, alloc_rob_tag, alloc_ready, i);
      end
      alloc(1, 6'(i + 30));
    end
    n_cmp++;
    if (alloc_ready !== 1'b0 || rob_count !== 5'd16) begin
      n_err++;
      $display("FAIL full: ready=%b count=%0d need 0/16", alloc_ready, rob_count);
    end
    alloc(1, 6'd63);
    n_cmp++;
    if (rob_count !== 5'd16 || q.size() != 16) begin
      n_err++;
      $display("FAIL full_ignore: count=%0d need 16", rob_count);
    end
    cdb(4'd0, 32'h55);
    tick();
    n_cmp++;
    if (commit_valid !== 1'b1 || commit_wr_val !== 32'h55 || commited_wr_register !== 6'd30) begin
      n_err++;
      $display("FAIL wrap_commit: cv=%b val=%h dst=%0d need 1/55/30", commit_valid, commit_wr_val, commited_wr_register);
    end
    n_cmp++;
    if (alloc_ready !== 1'b1 || alloc_rob_tag !== 4'd0 || rob_count !== 5'd15) begin
      n_err++;
      $display("FAIL wrap_tail: ready=%b tag=%0d count=%0d need 1/0/15", alloc_ready, alloc_rob_tag, rob_count);
    end
    alloc(0, 6'd1);
    n_cmp++;
    if (rob_count !== 5'd16 || alloc_ready !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_refill: count=%0d ready=%b need 16/0", rob_count, alloc_ready);
    end
  endtask

  task automatic test_no_dst();
    flush = 1; tick(); flush = 0;
    alloc(0, 6'd9);
    cdb(4'd0, 32'h77);
    tick();
    n_cmp++;
    if (commit_valid !== 1'b1 || commit_with_write !== 1'b0 || commit_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL nodst: cv=%b cw=%b wen=%b need 1/0/0", commit_valid, commit_with_write, commit_wr_en);
    end
  endtask

  task automatic test_flush();
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < 5; i++) alloc(1, 6'(i + 1));
    cdb(4'd2, 32'h22);
    flush = 1; cdb_valid = 1; cdb_rob_tag = 0; cdb_value = 32'h99;
    tick();
    idle();
    n_cmp++;
    if (rob_count !== 5'd0 || rob_empty !== 1'b1 || commit_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush: count=%0d empty=%b cv=%b need 0/1/0", rob_count, rob_empty, commit_valid);
    end
    cdb(4'd0, 32'h98);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (commit_valid !== 1'b0 || rob_count !== 5'd0) begin
        n_err++;
        $display("FAIL post_flush cyc%0d: cv=%b count=%0d need 0/0", c, commit_valid, rob_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < 3; i++) alloc(1, 6'(i + 40));
    cdb(4'd1, 32'h1);
    cdb(4'd2, 32'h2);
    cdb(4'd0, 32'h0);
    tick();
    n_cmp++;
    if (commit_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_pre: cv=%b need 1", commit_valid);
    end
    #2;
    reset = 0;
    #1;
    model_clear();
    n_cmp++;
    if (commit_valid !== 0 || commited_wr_register !== 0 || commit_pc !== 0 ||
        rob_count !== 0 || rob_empty !== 1 || alloc_ready !== 1) begin
      n_err++;
      $display("FAIL rmid_async: cv=%b dst=%0d cnt=%0d empty=%b ready=%b need 0/0/0/1/1",
               commit_valid, commited_wr_register, rob_count, rob_empty, alloc_ready);
    end
    @(posedge clk);
    #2;
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (commit_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rmid_quiet cyc%0d: cv=%b need 0", c, commit_valid);
      end
    end
    alloc(1, 6'd50);
    cdb(4'd0, 32'h5);
    tick();
    n_cmp++;
    if (commit_valid !== 1'b1 || commited_wr_register !== 6'd50) begin
      n_err++;
      $display("FAIL rmid_new: cv=%b dst=%0d need 1/50", commit_valid, commited_wr_register);
    end
  endtask

  task automatic test_random();
    int k;
    flush = 1; tick(); flush = 0;
    for (int c = 0; c < 600; c++) begin
      alloc_valid = ($urandom_range(0, 99) < 55);
      alloc_pc = $urandom;
      alloc_has_dst = $urandom_range(0, 1);
      alloc_dst_phy_reg = 6'($urandom);
      cdb_valid = 0;
      if ($urandom_range(0, 99) < 60) begin
        cdb_valid = 1;
        cdb_value = $urandom;
        cdb_rob_tag = 4'($urandom);
        if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
          k = $urandom_range(0, q.size() - 1);
          cdb_rob_tag = 4'(q[k].tag);
        end
      end
      flush = ($urandom_range(0, 99) < 2);
      n_cmp++;
      if (alloc_ready !== (q.size() < D) || alloc_rob_tag !== 4'(next_tag)) begin
        n_err++;
        $display("FAIL rnd_alloc cyc%0d: ready=%b tag=%0d need %b/%0d",
                 c, alloc_ready, alloc_rob_tag, q.size() < D, next_tag);
      end
      tick();
      n_cmp++;
      if (commit_valid !== e_cv || commit_with_write !== e_cw || commit_wr_en !== e_cw) begin
        n_err++;
        $display("FAIL rnd_cv cyc%0d: cv=%b cw=%b wen=%b need %b/%b/%b",
                 c, commit_valid, commit_with_write, commit_wr_en, e_cv, e_cw, e_cw);
      end
      n_cmp++;
      if (commited_wr_register !== e_dst || wr_commit_reg !== e_dst ||
          commit_wr_val !== e_val || commit_pc !== e_pc) begin
        n_err++;
        $display("FAIL rnd_data cyc%0d: dst=%0d/%0d val=%h pc=%h need %0d val=%h pc=%h",
                 c, commited_wr_register, wr_commit_reg, commit_wr_val, commit_pc, e_dst, e_val, e_pc);
      end
      n_cmp++;
      if (rob_count !== 5'(q.size()) || rob_empty !== (q.size() == 0)) begin
        n_err++;
        $display("FAIL rnd_count cyc%0d: count=%0d empty=%b need %0d", c, rob_count, rob_empty, q.size());
      end
    end
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_in_order();
    test_out_of_order();
    test_full_wrap();
    test_no_dst();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The block SHALL have parameter ROB_DEPTH, default 16, number of entries; a power of two, at least 2.
REQ-002 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port alloc_valid  in  1  dispatch requests one entry this cycle.
REQ-005 The block SHALL have port alloc_pc  in  `INST_ADDR_WIDTH  PC of the dispatched instruction.
REQ-006 The block SHALL have port alloc_has_dst  in  1  instruction writes a register.
REQ-007 The block SHALL have port alloc_dst_phy_reg  in  `PHYSICAL_REG_NUM_WIDTH  renamed destination.
REQ-008 The block SHALL have port alloc_ready  out  1  buffer not full.
REQ-009 The block SHALL have port alloc_rob_tag  out  ROB_TAG_WIDTH  tail index for the current allocation.
REQ-010 The block SHALL have port cdb_valid  in  1  execution result broadcast.
REQ-011 The block SHALL have port cdb_rob_tag  in  ROB_TAG_WIDTH  entry being completed.
REQ-012 The block SHALL have port cdb_value  in  `REG_VAL_WIDTH  result value.
REQ-013 The block SHALL have port flush  in  1  synchronous discard of all entries.
REQ-014 The block SHALL have ports commit_valid, commit_with_write  out  1 each  commit pulse and write flag, to rename.
REQ-015 The block SHALL have port commited_wr_register  out  `PHYSICAL_REG_NUM_WIDTH  committed destination, to rename.
REQ-016 The block SHALL have ports commit_wr_en  out  1, wr_commit_reg  out  `PHYSICAL_REG_NUM_WIDTH, commit_wr_val  out  `REG_VAL_WIDTH  physical regfile write.
REQ-017 The block SHALL have ports commit_pc  out  `INST_ADDR_WIDTH, rob_count  out  ROB_TAG_WIDTH+1, rob_empty  out  1.

Function
REQ-018 Storage SHALL be a circular buffer: head and tail pointers, each with a wrap bit; indices wrap modulo ROB_DEPTH.
REQ-019 alloc_ready SHALL be 1 when rob_count < ROB_DEPTH and SHALL NOT depend on a same-cycle commit.
REQ-020 When alloc_valid and alloc_ready are both 1, the entry at tail SHALL be written at the clock edge (valid=1, done=0, pc, has_dst, dst), and tail SHALL increment.
REQ-021 alloc_rob_tag SHALL equal the tail index combinationally; alloc_valid with alloc_ready=0 SHALL be ignored.
REQ-022 When cdb_valid is 1 and the addressed entry is valid, the entry SHALL set done=1 and store cdb_value at the edge; cdb_valid to an invalid entry SHALL be ignored.
REQ-023 At each edge where the head entry is valid and done, commit outputs SHALL load that entry, commit_valid SHALL be 1 for exactly one cycle, the entry SHALL be invalidated, and head SHALL increment.
REQ-024 The block SHALL commit at most one entry per cycle, in program order; a not-done head SHALL block younger done entries.
REQ-025 Latency: a CDB write at edge N to the head entry SHALL produce commit_valid=1 after edge N+1; there SHALL be no CDB-to-commit bypass.
REQ-026 commit_with_write and commit_wr_en SHALL equal has_dst during a commit pulse and 0 otherwise.
REQ-027 commited_wr_register and wr_commit_reg SHALL both carry dst, and commit_wr_val SHALL carry the stored value.
REQ-028 rob_count SHALL change by +1 on alloc only, -1 on commit only, and 0 on both in the same edge; rob_empty SHALL equal (rob_count==0).
REQ-029 Alloc and commit on the same entry index in the same cycle SHALL NOT occur, because alloc_ready=0 whenever the buffer is full.
REQ-030 flush SHALL have priority over alloc, CDB and commit: at the edge it SHALL clear all valid bits, set head=tail=0 and count=0, and drive commit outputs to 0 on the next cycle.

Reset
REQ-031 While reset=0, asynchronously: all entries SHALL be invalid, head=tail=0, rob_count=0, rob_empty=1, alloc_ready=1, and every commit output SHALL be 0.
REQ-032 Assertion of reset mid-operation SHALL discard all entries; no commit pulse SHALL follow deassertion until a new allocation completes.

Structure
REQ-033 rob_entry_t (valid, done, pc, has_dst, dst, value), ROB_DEPTH and ROB_TAG_WIDTH=$clog2(ROB_DEPTH) SHALL reside in the shared package.
REQ-034 The block SHALL contain one sub-module, rob_circ_ptr (wrapping pointer with wrap bit), instantiated for head and for tail.

Verification
REQ-035 Allocate 3 entries (dst 5,6,7), then CDB tags 0,1,2 with values 0xA,0xB,0xC -> three consecutive commit pulses, commited_wr_register 5,6,7 and commit_wr_val 0xA,0xB,0xC.
REQ-036 Out-of-order completion: CDB tag 1 before tag 0 -> no commit until tag 0 is done, then tags 0 and 1 commit on consecutive cycles.
REQ-037 Fill 16 entries -> alloc_ready=0 and rob_count=16; complete and commit the head -> alloc_ready=1, tail wraps to 0 and the next alloc_rob_tag is 0.
REQ-038 Entry with has_dst=0 completes -> commit_valid=1, commit_with_write=0, commit_wr_en=0.
REQ-039 flush with 5 entries pending and a CDB in the same cycle -> rob_count=0, rob_empty=1, no commit pulse afterwards.
REQ-040 reset=0 asserted between clock edges with entries done -> all outputs 0 immediately; after release, commit_valid stays 0 until a new allocation completes.
